// File: rtl/reg_move_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reg_move_sequencer
// Description : Sequences a MOV8 register-to-register transfer on the shared
//               data bus. The source select is driven first, the destination
//               load is pulsed inside the select window, and the select is
//               released last. Every output is registered.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_move_sequencer #(
    parameter int N     = 8,
    parameter int SETUP = 1,
    parameter int LOAD  = 2,
    parameter int HOLD  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       opcode,
    input  logic [8*N-1:0]   reg_data,
    output logic [7:0]       sel,
    output logic [7:0]       ld,
    output logic [N-1:0]     data_out,
    output logic             busy,
    output logic             done,
    output logic             illegal
);

    // The phase counter has to reach the longest of the three phase lengths.
    localparam int c_max_ab    = (SETUP > LOAD) ? SETUP : LOAD;
    localparam int c_max_phase = (c_max_ab > HOLD) ? c_max_ab : HOLD;
    localparam int c_cnt_w     = $clog2(c_max_phase) + 1;

    localparam logic [c_cnt_w-1:0] c_setup_last = c_cnt_w'(SETUP - 1);
    localparam logic [c_cnt_w-1:0] c_load_last  = c_cnt_w'(LOAD - 1);
    localparam logic [c_cnt_w-1:0] c_hold_last  = c_cnt_w'(HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEL  = 3'd1,
        S_LOAD = 3'd2,
        S_HOLD = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2:0]         r_src;
    logic [2:0]         r_dst;

    // Register file contents viewed as an array indexed by register number.
    logic [N-1:0] w_regs [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_unpack
            assign w_regs[gi] = reg_data[gi*N +: N];
        end
    endgenerate

    function automatic logic [7:0] f_onehot(input logic [2:0] idx);
        f_onehot = 8'b0000_0001 << idx;
    endfunction

    // Transfer state machine; outputs are loaded with the values of the state
    // being entered so that every strobe comes straight from a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_src    <= 3'd0;
            r_dst    <= 3'd0;
            sel      <= 8'h00;
            ld       <= 8'h00;
            data_out <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (opcode[7:6] == 2'b00) begin
                            r_src    <= opcode[2:0];
                            r_dst    <= opcode[5:3];
                            r_cnt    <= '0;
                            r_state  <= S_SEL;
                            sel      <= f_onehot(opcode[2:0]);
                            data_out <= w_regs[opcode[2:0]];
                            busy     <= 1'b1;
                        end else begin
                            illegal <= 1'b1;
                        end
                    end
                end
                S_SEL: begin
                    data_out <= w_regs[r_src];
                    if (r_cnt == c_setup_last) begin
                        r_cnt   <= '0;
                        r_state <= S_LOAD;
                        ld      <= f_onehot(r_dst);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_LOAD: begin
                    data_out <= w_regs[r_src];
                    if (r_cnt == c_load_last) begin
                        r_cnt   <= '0;
                        r_state <= S_HOLD;
                        ld      <= 8'h00;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (r_cnt == c_hold_last) begin
                        // Select drops only after the load has been low for HOLD cycles.
                        r_cnt    <= '0;
                        r_state  <= S_DONE;
                        sel      <= 8'h00;
                        data_out <= '0;
                        done     <= 1'b1;
                    end else begin
                        data_out <= w_regs[r_src];
                        r_cnt    <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    // start is not looked at here; the next request is taken from IDLE.
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_cnt    <= '0;
                    r_state  <= S_IDLE;
                    sel      <= 8'h00;
                    ld       <= 8'h00;
                    data_out <= '0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
